// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared codes for the ALU control decoder and MULT/DIV sequencer.
// Holds ALU control codes, funct/alu_op codes and the sequencer state type.
// Optional feature macro: ALU_MD_DIV_EN (adds DIV codes and the DIV state).
package alu_md_pkg;

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_XOR  = 4'b0100;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_SLL  = 4'b1000;
    localparam logic [3:0] CTRL_SRL  = 4'b1001;
    localparam logic [3:0] CTRL_SRA  = 4'b1010;
    localparam logic [3:0] CTRL_MULT = 4'b0101;
`ifdef ALU_MD_DIV_EN
    localparam logic [3:0] CTRL_DIV  = 4'b1011;
`endif

    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_MULT = 6'b011000;
`ifdef ALU_MD_DIV_EN
    localparam logic [5:0] F_DIV  = 6'b011010;
`endif

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_AND   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
`ifdef ALU_MD_DIV_EN
        ,
        S_DIV  = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/alu_md_datapath.sv
// alu_md_datapath: magnitude shift-add multiplier / restoring divider step
// plus sign fix-up of the result.
// Ports: clk, reset (sync, active-high), start (load operands),
//   step (one iteration), div_mode (ALU_MD_DIV_EN only), op_a, op_b,
//   res_hi/res_lo (sign-fixed result of the values after this step).
// Optional feature macro: ALU_MD_DIV_EN (builds the divider path).
module alu_md_datapath
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
`ifdef ALU_MD_DIV_EN
    input  logic             div_mode,
`endif
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   low;
    logic               neg_res;
    logic [WIDTH:0]     acc_nx;
    logic [WIDTH-1:0]   low_nx;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     mul_acc;
    logic [WIDTH-1:0]   mul_low;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    // Magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;
    assign mag_a_in = op_a[WIDTH-1] ? -op_a : op_a;
    assign mag_b_in = op_b[WIDTH-1] ? -op_b : op_b;

    // Multiply: {acc, low} shifts right, adding the multiplicand on low[0].
    assign sum      = low[0] ? acc + {1'b0, mag_b} : acc;
    assign mul_acc  = {1'b0, sum[WIDTH:1]};
    assign mul_low  = {sum[0], low[WIDTH-1:1]};
    assign prod     = {mul_acc[WIDTH-1:0], mul_low};
    assign prod_fix = neg_res ? -prod : prod;

`ifdef ALU_MD_DIV_EN
    logic             neg_rem;
    logic             mode_q;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH:0]   div_acc;
    logic [WIDTH-1:0] div_low;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    // Restoring divide: remainder in acc, dividend shifts out of low
    // while quotient bits shift in.
    assign shifted = {acc[WIDTH-1:0], low[WIDTH-1]};
    assign ge      = shifted >= {1'b0, mag_b};
    assign div_acc = ge ? shifted - {1'b0, mag_b} : shifted;
    assign div_low = {low[WIDTH-2:0], ge};
    assign quo     = neg_res ? -div_low : div_low;
    assign rem     = neg_rem ? -div_acc[WIDTH-1:0]
                             : div_acc[WIDTH-1:0];

    assign acc_nx  = mode_q ? div_acc : mul_acc;
    assign low_nx  = mode_q ? div_low : mul_low;
    assign res_hi  = mode_q ? rem : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo  = mode_q ? quo : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_rem <= 1'b0;
            mode_q  <= 1'b0;
        end else if (start) begin
            neg_rem <= op_a[WIDTH-1];
            mode_q  <= div_mode;
        end
    end
`else
    assign acc_nx  = mul_acc;
    assign low_nx  = mul_low;
    assign res_hi  = prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo  = prod_fix[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            mag_b   <= '0;
            acc     <= '0;
            low     <= '0;
            neg_res <= 1'b0;
        end else if (start) begin
            mag_b   <= mag_b_in;
            acc     <= '0;
            low     <= mag_a_in;
            neg_res <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
        end else if (step) begin
            acc     <= acc_nx;
            low     <= low_nx;
        end
    end

endmodule

// File: rtl/alu_md_sequencer.sv
// alu_md_sequencer: ALU control decoder plus multi-cycle signed MULT/DIV
// into HI/LO, stalling the execute stage while an operation runs.
// Ports: clk, reset (sync, active-high), valid_in, alu_op[1:0], funct[5:0],
//   op_a/op_b; out alu_ctrl[3:0], illegal, stall, md_done, div_by_zero,
//   hi/lo.
// Optional feature macro: ALU_MD_DIV_EN (DIV decode and sequencing).
module alu_md_sequencer
    import alu_md_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [3:0]       alu_ctrl,
    output logic             illegal,
    output logic             stall,
    output logic             md_done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             dz, dz_nx;
    logic             is_mul, is_div;
    logic             start, step, wr, div_sel;
    logic [WIDTH-1:0] hi_nx, lo_nx;
    logic [WIDTH-1:0] dp_hi, dp_lo;

    always_comb begin
        alu_ctrl = CTRL_AND;
        illegal  = 1'b0;
        is_mul   = 1'b0;
        is_div   = 1'b0;
        unique case (alu_op)
            OP_ADD: alu_ctrl = CTRL_ADD;
            OP_SUB: alu_ctrl = CTRL_SUB;
            OP_AND: alu_ctrl = CTRL_AND;
            OP_RTYPE: begin
                unique case (funct)
                    F_AND:  alu_ctrl = CTRL_AND;
                    F_OR:   alu_ctrl = CTRL_OR;
                    F_ADD:  alu_ctrl = CTRL_ADD;
                    F_SUB:  alu_ctrl = CTRL_SUB;
                    F_XOR:  alu_ctrl = CTRL_XOR;
                    F_NOR:  alu_ctrl = CTRL_NOR;
                    F_SLT:  alu_ctrl = CTRL_SLT;
                    F_SLL:  alu_ctrl = CTRL_SLL;
                    F_SRL:  alu_ctrl = CTRL_SRL;
                    F_SRA:  alu_ctrl = CTRL_SRA;
                    F_MULT: begin
                        alu_ctrl = CTRL_MULT;
                        is_mul   = 1'b1;
                    end
`ifdef ALU_MD_DIV_EN
                    F_DIV: begin
                        alu_ctrl = CTRL_DIV;
                        is_div   = 1'b1;
                    end
`endif
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        dz_nx    = 1'b0;
        stall    = 1'b0;
        start    = 1'b0;
        step     = 1'b0;
        wr       = 1'b0;
        div_sel  = 1'b0;
        hi_nx    = dp_hi;
        lo_nx    = dp_lo;
        unique case (state)
            S_IDLE: begin
                if (valid_in && is_mul) begin
                    stall    = 1'b1;
                    start    = 1'b1;
                    cnt_nx   = CNT_W'(WIDTH);
                    state_nx = S_MUL;
                end
`ifdef ALU_MD_DIV_EN
                else if (valid_in && is_div) begin
                    stall = 1'b1;
                    if (op_b == '0) begin
                        // Divide by zero finishes at once with a fixed result.
                        wr       = 1'b1;
                        hi_nx    = op_a;
                        lo_nx    = '1;
                        dz_nx    = 1'b1;
                        state_nx = S_DONE;
                    end else begin
                        start    = 1'b1;
                        div_sel  = 1'b1;
                        cnt_nx   = CNT_W'(WIDTH);
                        state_nx = S_DIV;
                    end
                end
`endif
            end
            S_MUL: begin
                stall  = 1'b1;
                step   = 1'b1;
                cnt_nx = cnt - CNT_W'(1);
                // Last iteration: capture the fixed-up result so hi/lo
                // are already valid while md_done is high.
                if (cnt == CNT_W'(1)) begin
                    wr       = 1'b1;
                    state_nx = S_DONE;
                end
            end
`ifdef ALU_MD_DIV_EN
            S_DIV: begin
                stall  = 1'b1;
                step   = 1'b1;
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    wr       = 1'b1;
                    state_nx = S_DONE;
                end
            end
`endif
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            dz    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            dz    <= dz_nx;
            if (wr) begin
                hi <= hi_nx;
                lo <= lo_nx;
            end
        end
    end

    assign md_done     = (state == S_DONE);
    assign div_by_zero = dz;

    alu_md_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .step     (step),
`ifdef ALU_MD_DIV_EN
        .div_mode (div_sel),
`endif
        .op_a     (op_a),
        .op_b     (op_b),
        .res_hi   (dp_hi),
        .res_lo   (dp_lo)
    );

endmodule

// File: tb/tb_alu_md_sequencer.sv
// tb_alu_md_sequencer: directed test of decode, MULT/DIV results and timing,
// with a cycle-level reference model checked on every negedge.
module tb_alu_md_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_in;
    logic [1:0]   alu_op;
    logic [5:0]   funct;
    logic [W-1:0] op_a, op_b;
    logic [3:0]   alu_ctrl;
    logic         illegal, stall, md_done, div_by_zero;
    logic [W-1:0] hi, lo;

    always #5 clk = ~clk;

    alu_md_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .alu_op      (alu_op),
        .funct       (funct),
        .op_a        (op_a),
        .op_b        (op_b),
        .alu_ctrl    (alu_ctrl),
        .illegal     (illegal),
        .stall       (stall),
        .md_done     (md_done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Decode table straight from the instruction encoding.
    function automatic void exp_dec(input logic [1:0] op, input logic [5:0] f,
                                    output logic [3:0] c, output logic ill,
                                    output logic mu, output logic dv);
        c = 4'b0000; ill = 1'b0; mu = 1'b0; dv = 1'b0;
        if (op == 2'b00)      c = 4'b0010;
        else if (op == 2'b01) c = 4'b0110;
        else if (op == 2'b11) c = 4'b0000;
        else begin
            case (f)
                6'b100100: c = 4'b0000;
                6'b100101: c = 4'b0001;
                6'b100000: c = 4'b0010;
                6'b100010: c = 4'b0110;
                6'b100110: c = 4'b0100;
                6'b100111: c = 4'b1100;
                6'b101010: c = 4'b0111;
                6'b000000: c = 4'b1000;
                6'b000010: c = 4'b1001;
                6'b000011: c = 4'b1010;
                6'b011000: begin c = 4'b0101; mu = 1'b1; end
`ifdef ALU_MD_DIV_EN
                6'b011010: begin c = 4'b1011; dv = 1'b1; end
`endif
                default: ill = 1'b1;
            endcase
        end
    endfunction

    // Reference model: cycles left until done, and the result to publish.
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic         m_dz   = 1'b0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;
    logic [W-1:0] p_hi   = '0;
    logic [W-1:0] p_lo   = '0;
    bit           chk_en = 1'b0;

    always @(posedge clk) begin
        logic [3:0] c;
        logic il, mu, dv;
        longint sa, sb, pr, q, r;
        exp_dec(alu_op, funct, c, il, mu, dv);
        if (reset) begin
            m_left = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi; m_lo = p_lo; m_done = 1; m_dz = 0;
            end
        end else if (m_done) begin
            m_done = 0; m_dz = 0;
        end else if (valid_in && (mu || dv)) begin
            sa = longint'($signed(op_a));
            sb = longint'($signed(op_b));
            if (mu) begin
                pr = sa * sb;
                p_hi = pr[63:32]; p_lo = pr[31:0];
                m_left = W;
            end else if (sb == 0) begin
                m_hi = op_a; m_lo = '1; m_dz = 1; m_done = 1;
            end else begin
                q = sa / sb; r = sa % sb;
                p_lo = q[31:0]; p_hi = r[31:0];
                m_left = W;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] c;
        logic il, mu, dv, es;
        if (chk_en) begin
            exp_dec(alu_op, funct, c, il, mu, dv);
            es = (m_left > 0) || (!m_done && valid_in && (mu || dv));
            chk("alu_ctrl", 64'(alu_ctrl), 64'(c));
            chk("illegal", 64'(illegal), 64'(il));
            chk("stall", 64'(stall), 64'(es));
            chk("md_done", 64'(md_done), 64'(m_done));
            chk("div_by_zero", 64'(div_by_zero), 64'(m_dz));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_md(input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int done_cyc,
                          output int stall_cnt, output logic dz);
        alu_op = 2'b10; funct = f; op_a = a; op_b = b; valid_in = 1'b1;
        done_cyc = -1; stall_cnt = 0; dz = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (md_done) begin
                done_cyc = cyc;
                dz = div_by_zero;
                break;
            end
            step();
        end
        if (done_cyc < 0) begin
            total++; bad++;
            $display("FAIL md_timeout got=none want=md_done");
        end
        step();
        valid_in = 1'b0;
    endtask

    logic [5:0] sweep [11] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010,
                               6'b100110, 6'b100111, 6'b101010, 6'b000000,
                               6'b000010, 6'b000011, 6'b111111};

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int dc, sc;
        logic dz;
        logic [1:0] ops [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        reset = 1'b1; valid_in = 1'b0; alu_op = 2'b00; funct = 6'b0;
        op_a = '0; op_b = '0;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_md_done", 64'(md_done), 64'h0);
        step();

        // Decode sweep across all alu_op values and plain R-type functs.
        valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 11; j++) begin
                alu_op = ops[i]; funct = sweep[j];
                op_a = $urandom; op_b = $urandom;
                step();
            end
        end
        alu_op = 2'b10; funct = 6'b100010;
        @(negedge clk);
        chk("sub_ctrl", 64'(alu_ctrl), 64'h6);
        chk("sub_illegal", 64'(illegal), 64'h0);
        chk("sub_stall", 64'(stall), 64'h0);
        step();
        funct = 6'b111111;
        @(negedge clk);
        chk("bad_funct_illegal", 64'(illegal), 64'h1);
        chk("bad_funct_ctrl", 64'(alu_ctrl), 64'h0);
        step();
        valid_in = 1'b0;
        step();

        run_md(6'b011000, -32'sd3, 32'sd7, dc, sc, dz);
        chk("mul_done_cyc", 64'(dc), 64'd33);
        chk("mul_stall_cnt", 64'(sc), 64'd33);
        chk("mul_hi", 64'(hi), 64'hFFFFFFFF);
        chk("mul_lo", 64'(lo), 64'hFFFFFFEB);
        step();
        run_md(6'b011000, 32'h80000000, 32'h80000000, dc, sc, dz);
        chk("mul_minmin_hi", 64'(hi), 64'h40000000);
        chk("mul_minmin_lo", 64'(lo), 64'h0);
        run_md(6'b011000, 32'h7FFFFFFF, 32'h80000000, dc, sc, dz);
        run_md(6'b011000, 32'hFFFFFFFF, 32'hFFFFFFFF, dc, sc, dz);
        chk("mul_m1m1_lo", 64'(lo), 64'h1);
        run_md(6'b011000, 32'h12345678, 32'h0, dc, sc, dz);

`ifdef ALU_MD_DIV_EN
        run_md(6'b011010, -32'sd7, 32'sd2, dc, sc, dz);
        chk("div_done_cyc", 64'(dc), 64'd33);
        chk("div_lo", 64'(lo), 64'hFFFFFFFD);
        chk("div_hi", 64'(hi), 64'hFFFFFFFF);
        chk("div_dz", 64'(dz), 64'h0);
        run_md(6'b011010, 32'sd7, -32'sd2, dc, sc, dz);
        run_md(6'b011010, -32'sd100, 32'sd7, dc, sc, dz);
        run_md(6'b011010, 32'sd3, 32'sd10, dc, sc, dz);
        run_md(6'b011010, 32'h80000000, 32'hFFFFFFFF, dc, sc, dz);
        chk("div_wrap_lo", 64'(lo), 64'h80000000);
        chk("div_wrap_hi", 64'(hi), 64'h0);
        run_md(6'b011010, 32'sd5, 32'sd0, dc, sc, dz);
        chk("dz_done_cyc", 64'(dc), 64'd1);
        chk("dz_stall_cnt", 64'(sc), 64'd1);
        chk("dz_flag", 64'(dz), 64'h1);
        chk("dz_hi", 64'(hi), 64'h5);
        chk("dz_lo", 64'(lo), 64'hFFFFFFFF);
`else
        alu_op = 2'b10; funct = 6'b011010; op_a = 5; op_b = 2;
        valid_in = 1'b1;
        @(negedge clk);
        chk("nodiv_illegal", 64'(illegal), 64'h1);
        chk("nodiv_stall", 64'(stall), 64'h0);
        chk("nodiv_ctrl", 64'(alu_ctrl), 64'h0);
        step();
        @(negedge clk);
        chk("nodiv_stall2", 64'(stall), 64'h0);
        step();
        valid_in = 1'b0;
        run_md(6'b011000, 32'sd5, -32'sd9, dc, sc, dz);
`endif

        // Abort a multiply with reset during cycle 10.
        step();
        alu_op = 2'b10; funct = 6'b011000; op_a = 6; op_b = 7;
        valid_in = 1'b1;
        for (int k = 0; k < 10; k++) step();
        reset = 1'b1; valid_in = 1'b0;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_stall", 64'(stall), 64'h0);
        chk("abort_hi", 64'(hi), 64'h0);
        chk("abort_lo", 64'(lo), 64'h0);
        step();
        run_md(6'b011000, 32'sd6, 32'sd7, dc, sc, dz);
        chk("retry_lo", 64'(lo), 64'h2A);
        chk("retry_hi", 64'(hi), 64'h0);
        chk("retry_done_cyc", 64'(dc), 64'd33);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
